// File: rtl/vc_arb_pkg.sv
// Shared types for the VC packet arbiter: FSM states, default widths, request beat layout.
package vc_arb_pkg;

  localparam int unsigned NUM_REQ_DEF          = 4;
  localparam int unsigned WIDTH_DATA_DEF       = 16;
  localparam int unsigned ADDRESS_WIDTH_DEF    = 4;
  localparam int unsigned VC_ADDRESS_WIDTH_DEF = 1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [WIDTH_DATA_DEF-1:0]       data;
    logic [ADDRESS_WIDTH_DEF-1:0]    dest;
    logic [VC_ADDRESS_WIDTH_DEF-1:0] vc;
    logic                            lock;
  } req_t;

  // Index width that stays at least one bit for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: one-hot grant of the first valid bit at or after ptr, wrapping upward.
// Purely combinational; no backpressure, the caller decides whether the grant is consumed.
module rr_pick
  import vc_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_vld
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!found && vld[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

  assign gnt_vld = |vld;

endmodule

// File: rtl/vc_pkt_arbiter.sv
// N:1 round-robin arbiter with burst locking into a one-entry output register; 1-cycle latency, 1 beat/cycle.
// Backpressure: i_ready_out is all-zero unless the register is empty or draining. VC_ARB_STATS_EN adds per-requester grant counters.
module vc_pkt_arbiter
  import vc_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ          = 4,
  parameter  int unsigned WIDTH_DATA       = 16,
  parameter  int unsigned ADDRESS_WIDTH    = 4,
  parameter  int unsigned VC_ADDRESS_WIDTH = 1,
  parameter  int unsigned MAX_BURST        = 8,
  localparam int unsigned IDW              = idx_w(NUM_REQ)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0][WIDTH_DATA-1:0]         i_data_in,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]      i_dest_in,
  input  logic [NUM_REQ-1:0][VC_ADDRESS_WIDTH-1:0]   i_vc_in,
  input  logic [NUM_REQ-1:0]                         i_lock_in,
  input  logic [NUM_REQ-1:0]                         i_valid_in,
  output logic [NUM_REQ-1:0]                         i_ready_out,
  output logic [WIDTH_DATA-1:0]                      o_data_out,
  output logic [ADDRESS_WIDTH-1:0]                   o_dest_out,
  output logic [VC_ADDRESS_WIDTH-1:0]                o_vc_out,
  output logic                                       o_valid_out,
  input  logic                                       o_ready_in,
  output logic [IDW-1:0]                             o_grant_id
`ifdef VC_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]                   o_grant_count
`endif
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic [WIDTH_DATA-1:0]       data;
    logic [ADDRESS_WIDTH-1:0]    dest;
    logic [VC_ADDRESS_WIDTH-1:0] vc;
    logic [IDW-1:0]              id;
  } beat_t;

  arb_state_e         state, state_nxt;
  logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]     owner, owner_nxt;
  logic [CW-1:0]      burst_cnt, burst_cnt_nxt;
  logic [IDW-1:0]     pick_ptr, win_id;
  logic [NUM_REQ-1:0] elig_vld, win_gnt;
  logic               win_vld, win_lock;
  logic               load_rdy, accept;
  logic               out_vld;
  beat_t              out_q, win_beat;

  // While locked, the owner is the only candidate; an idle owner stalls everyone.
  assign elig_vld = (state == ARB) ? i_valid_in : (i_valid_in & (NUM_REQ'(1) << owner));
  assign pick_ptr = (state == ARB) ? rr_ptr : owner;

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .vld    (elig_vld),
    .ptr    (pick_ptr),
    .gnt    (win_gnt),
    .gnt_id (win_id),
    .gnt_vld(win_vld)
  );

  assign load_rdy    = !rst && (!out_vld || o_ready_in);
  assign accept      = load_rdy && win_vld;
  assign i_ready_out = load_rdy ? win_gnt : '0;
  assign win_lock    = i_lock_in[win_id];

  always_comb begin
    win_beat      = '0;
    win_beat.data = i_data_in[win_id];
    win_beat.dest = i_dest_in[win_id];
    win_beat.vc   = i_vc_in[win_id];
    win_beat.id   = win_id;
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    rr_ptr_nxt    = rr_ptr;
    if (accept) begin
      case (state)
        ARB: begin
          rr_ptr_nxt = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
          if (win_lock && (MAX_BURST > 1)) begin
            state_nxt     = LOCKED;
            owner_nxt     = win_id;
            burst_cnt_nxt = CW'(1);
          end
        end
        LOCKED: begin
          // The beat that brings the count to MAX_BURST ends the burst even if lock stays high.
          if (!win_lock || ((burst_cnt + CW'(1)) >= CW'(MAX_BURST))) begin
            state_nxt     = ARB;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + CW'(1);
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (accept) begin
      out_vld <= 1'b1;
      out_q   <= win_beat;
    end else if (o_ready_in) begin
      out_vld <= 1'b0;
    end
  end

  assign o_valid_out = out_vld;
  assign o_data_out  = out_q.data;
  assign o_dest_out  = out_q.dest;
  assign o_vc_out    = out_q.vc;
  assign o_grant_id  = out_q.id;

`ifdef VC_ARB_STATS_EN
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_grant_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        o_grant_count[r] <= '0;
      end else if (i_ready_out[r] && i_valid_in[r] && (o_grant_count[r] != '1)) begin
        o_grant_count[r] <= o_grant_count[r] + 32'd1;
      end
    end
  end
`endif

endmodule
